// File: rtl/disaggregator.sv
// Wide-to-narrow width converter: buffers packed FETCH_WIDTH-lane words in a
// small ring and replays them one DATA_WIDTH lane per transfer, lane 0 first.
module disaggregator #(
  parameter int DATA_WIDTH  = 11,
  parameter int FETCH_WIDTH = 4,
  parameter int DEPTH       = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] in_data,
  input  logic                              in_enq,
  output logic                              in_full_n,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_enq,
  input  logic                              out_full_n,
  output logic                              out_last,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              err_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(FETCH_WIDTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [LW-1:0] LANE_LAST = LW'(FETCH_WIDTH-1);

  logic [FETCH_WIDTH*DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0]             head_lanes [FETCH_WIDTH];
  logic [PW-1:0]                     wr_ptr;
  logic [PW-1:0]                     rd_ptr;
  logic [LW-1:0]                     lane;
  logic                              empty;
  logic                              push;
  logic                              pop;

  // Full blocks pushes even when the head pops this cycle: no pass-through.
  assign empty     = (count == '0);
  assign in_full_n = (count != CNT_FULL);
  assign push      = in_enq && in_full_n;
  assign out_enq   = !empty && out_full_n;
  assign pop       = out_enq && (lane == LANE_LAST);
  assign out_last  = pop;

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      head_lanes[i] = mem[rd_ptr][i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign out_data = empty ? '0 : head_lanes[lane];

  // Buffer storage carries data only and is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      lane         <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (out_enq) begin
        lane <= pop ? '0 : lane + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (in_enq && !in_full_n) begin
        err_overflow <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_disaggregator.sv
// Scoreboard bench for disaggregator: the driver queues expected narrow words
// per accepted wide word, and a negedge monitor checks every transfer.
module tb_disaggregator;

  localparam int DW = 11;
  localparam int FW = 4;
  localparam int DP = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [FW*DW-1:0] in_data;
  logic             in_enq;
  logic             in_full_n;
  logic [DW-1:0]    out_data;
  logic             out_enq;
  logic             out_full_n;
  logic             out_last;
  logic [1:0]       count;
  logic             err_overflow;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic drv_done;

  disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_enq(in_enq),
    .in_full_n(in_full_n), .out_data(out_data), .out_enq(out_enq),
    .out_full_n(out_full_n), .out_last(out_last), .count(count),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [FW*DW-1:0] mk(input int base);
    logic [FW*DW-1:0] w;
    for (int l = 0; l < FW; l++) w[l*DW +: DW] = DW'(base + l);
    return w;
  endfunction

  task automatic queue_word(input int base);
    exp_t e;
    for (int l = 0; l < FW; l++) begin
      e.data = DW'(base + l);
      e.last = (l == FW-1);
      q.push_back(e);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic push_word(input int base);
    int n = 0;
    while (!in_full_n && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_full_n) chk("push_wait_timeout", 0, 1);
    in_data = mk(base);
    in_enq  = 1'b1;
    queue_word(base);
    @(posedge clk); #1;
    in_enq = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, q.size(), 0);
  endtask

  // Monitor: every transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (out_enq) begin
      if (q.size() == 0) begin
        chk("unexpected_output", out_data, 32'hFFFF);
      end else begin
        e = q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_last", out_last, e.last);
      end
    end else if (out_last) begin
      chk("out_last_without_enq", out_last, 0);
    end
  end

  initial begin
    rst        = 1'b0;
    in_enq     = 1'b0;
    in_data    = '0;
    out_full_n = 1'b1;
    drv_done   = 1'b0;
    #1 rst = 1'b1;

    // Reset with in_enq held high
    in_enq  = 1'b1;
    in_data = mk(50);
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_full_n", in_full_n, 1);
      chk("rst_out_enq", out_enq, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_count", count, 0);
      chk("rst_err", err_overflow, 0);
    end
    @(posedge clk); #1;
    in_enq = 1'b0;
    rst    = 1'b0;

    // Single word, lanes 10..13
    push_word(10);
    chk("single_count_after_push", count, 1);
    repeat (4) begin
      @(negedge clk);
      chk("single_out_enq_run", out_enq, 1);
    end
    @(negedge clk);
    chk("single_out_enq_end", out_enq, 0);
    chk("single_count_end", count, 0);
    chk("single_data_idle", out_data, 0);

    // Fill and overflow
    @(posedge clk); #1;
    out_full_n = 1'b0;
    push_word(100);
    push_word(200);
    chk("fill_count", count, 2);
    chk("fill_in_full_n", in_full_n, 0);
    in_data = mk(300);
    in_enq  = 1'b1;
    @(posedge clk); #1;
    in_enq = 1'b0;
    chk("ovf_err", err_overflow, 1);
    chk("ovf_count", count, 2);
    out_full_n = 1'b1;
    drain("ovf_drain");
    chk("ovf_count_end", count, 0);
    chk("ovf_err_sticky", err_overflow, 1);

    // Mid-word stall holding lane 2
    push_word(400);
    @(posedge clk);
    @(posedge clk); #1;
    out_full_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_out_enq", out_enq, 0);
      chk("stall_out_data", out_data, 402);
      @(posedge clk);
    end
    #1 out_full_n = 1'b1;
    drain("stall_drain");

    // Full buffer with last-lane pop: push refused that cycle
    out_full_n = 1'b0;
    push_word(500);
    push_word(600);
    chk("full_count", count, 2);
    out_full_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_data = mk(700);
    in_enq  = 1'b1;
    @(negedge clk);
    chk("fullpop_in_full_n", in_full_n, 0);
    chk("fullpop_out_last", out_last, 1);
    @(posedge clk); #1;
    chk("fullpop_count", count, 1);
    chk("fullpop_in_full_n_after", in_full_n, 1);
    queue_word(700);
    @(posedge clk); #1;
    in_enq = 1'b0;
    chk("fullpop_count_after_push", count, 2);
    drain("fullpop_drain");

    // Reset mid-word discards buffered data and lane position
    push_word(800);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midrst_out_enq", out_enq, 0);
    chk("midrst_count", count, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_full_n", in_full_n, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_err", err_overflow, 0);
    push_word(900);
    drain("midrst_drain");

    // Streaming with random upstream idles and downstream backpressure
    fork
      begin
        for (int k = 0; k < 200; k++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          push_word(4 * k);
        end
        drv_done = 1'b1;
      end
      begin
        int n = 0;
        while ((!drv_done || q.size() != 0) && n < 20000) begin
          @(posedge clk); #1;
          out_full_n = ($urandom_range(0, 3) != 0);
          n++;
        end
        chk("stream_timeout", n < 20000, 1);
        out_full_n = 1'b1;
      end
    join
    @(posedge clk); #1;
    chk("stream_queue_empty", q.size(), 0);
    chk("stream_count_end", count, 0);
    chk("stream_err", err_overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
